store_aligner: RTL and testbench
================================

Name: store_aligner

Overview:
- Store-side counterpart of the load extraction path: takes a store request (opcode, fn3, byte address, rs2 value) and drives the data-memory write interface.
- Places the SB/SH/SW data into the correct byte lanes and generates byte enables.
- Splits stores that cross a word boundary into two word-aligned beats, using a valid/ready handshake toward memory.
- Sits between the execute stage and the data memory write port.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split word-crossing stores into two beats; 0 = flag them as an error with no memory write.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- opcode  in  7  instruction opcode; 7'b0100011 = store.
- fn3  in  3  000 SB, 001 SH, 010 SW; 011-111 illegal.
- addr  in  32  byte address.
- store_val  in  32  rs2 value; low byte/half used for SB/SH.
- mem_valid  out  1  write beat present.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  32  word-aligned address; bits [1:0] always 00.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i = byte lane i.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: request rejected.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - req_ready = 1; mem_valid, mem_addr, mem_wdata, mem_be, done, err = 0.
  - Reset during any beat aborts the transaction, and mem_valid drops at once. No partial beat is replayed after reset.
- States: IDLE, BEAT0, BEAT1. req_ready = 1 only in IDLE. All outputs are registered.
- Acceptance happens at an edge where req_valid && req_ready. Request fields are captured at that edge and used from then on; input changes after acceptance have no effect.
- Alignment (computed at acceptance):
  - off = addr[1:0]; base mask: SB 0001, SH 0011, SW 1111.
  - 64-bit data = zero-extended size-masked store_val << (8*off).
  - 8-bit mask = base mask << off.
  - Beat0: addr {addr[31:2],2'b00}, wdata = data[31:0], be = mask[3:0].
  - Beat1 is needed iff mask[7:4] != 0: addr = beat0 addr + 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), wdata = data[63:32], be = mask[7:4].
  - Disabled byte lanes of mem_wdata are driven 0.
- Transitions:
  - IDLE to BEAT0 on acceptance of a legal store. mem_valid = 1 from the cycle after acceptance.
  - BEAT0: hold mem_valid and the full payload stable until mem_ready. On the handshake, go to BEAT1 if beat1 is needed (payload updates next cycle, mem_valid stays 1); otherwise go to IDLE.
  - BEAT1: hold until mem_ready; on the handshake go to IDLE.
  - On the final handshake: mem_valid = 0 and done = 1 (err = 0) in the next cycle, which is also an IDLE cycle. A new request may be accepted in that cycle (back-to-back).
- Errors and no-ops:
  - Reject (done = 1, err = 1 the cycle after acceptance, no mem_valid, stay in IDLE) when fn3 is 011-111 with a store opcode, or when ALLOW_MISALIGNED = 0 and beat1 would be needed.
  - Non-store opcode: accepted as a no-op; done = 1, err = 0 the next cycle, no beat.
- Latency with mem_ready tied high: aligned store accepted at edge T gives mem_valid in T..T+1 and done in T+1..T+2. A split store completes one cycle later.
- done and err are never high for more than one cycle per request.

Test Plan:
1. SB, addr 0x00001003, store_val 0xAABBCCDD, mem_ready = 1 → one beat: mem_addr 0x00001000, be 1000, wdata 0xDD000000. Then done = 1, err = 0.
2. SH, addr 0x00002002, store_val 0xFFFF1234 → one beat: mem_addr 0x00002000, be 1100, wdata 0x12340000.
3. SW, addr 0x00003001, store_val 0x11223344 → beat0: 0x00003000, be 1110, wdata 0x22334400. beat1: 0x00003004, be 0001, wdata 0x00000011. One done pulse. SW at 0xFFFFFFFE → beat1 mem_addr 0x00000000, be 0011.
4. SW 0x00004000 with mem_ready low for 3 cycles → mem_valid and payload stable for 4 cycles, exactly one handshake, req_ready = 0 throughout.
5. fn3 = 011 with a store opcode → no mem_valid, done = err = 1 for one cycle. With ALLOW_MISALIGNED = 0, SH at 0x00000003 → same error response. opcode 0000011 → done = 1, err = 0, no beat.
6. Assert rst mid-BEAT1 of case 3 → mem_valid = 0 immediately, no done. After release, req_ready = 1 and a new SB completes normally.

Source files
------------

// File: rtl/store_aligner.sv
// Store data aligner: places SB/SH/SW data in the correct byte lanes, builds byte
// enables and splits word-crossing stores into two word-aligned write beats.
module store_aligner #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  fn3,
  input  logic [31:0] addr,
  input  logic [31:0] store_val,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  logic [1:0]  state;

  logic [31:0] sized_val;
  logic [3:0]  base_mask;
  logic        legal_size;
  logic [63:0] data_wide;
  logic [7:0]  mask_wide;
  logic        need_beat1;
  logic [31:0] beat0_addr;

  logic [31:0] beat1_addr;
  logic [31:0] beat1_wdata;
  logic [3:0]  beat1_be;
  logic        has_beat1;

  // Alignment of the incoming request, consumed only at the acceptance edge.
  always_comb begin
    sized_val  = '0;
    base_mask  = '0;
    legal_size = 1'b1;
    case (fn3)
      3'b000: begin
        sized_val = {24'b0, store_val[7:0]};
        base_mask = 4'b0001;
      end
      3'b001: begin
        sized_val = {16'b0, store_val[15:0]};
        base_mask = 4'b0011;
      end
      3'b010: begin
        sized_val = store_val;
        base_mask = 4'b1111;
      end
      default: legal_size = 1'b0;
    endcase
    data_wide  = {32'b0, sized_val} << {addr[1:0], 3'b000};
    mask_wide  = {4'b0, base_mask} << addr[1:0];
    need_beat1 = |mask_wide[7:4];
  end

  assign beat0_addr = {addr[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      beat1_addr  <= '0;
      beat1_wdata <= '0;
      beat1_be    <= '0;
      has_beat1   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (opcode != OP_STORE) begin
              done <= 1'b1;
            end else if (!legal_size || (!ALLOW_MISALIGNED && need_beat1)) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state       <= BEAT0;
              req_ready   <= 1'b0;
              mem_valid   <= 1'b1;
              mem_addr    <= beat0_addr;
              mem_wdata   <= data_wide[31:0];
              mem_be      <= mask_wide[3:0];
              // Beat1 payload is captured now so later input changes cannot leak in.
              beat1_addr  <= beat0_addr + 32'd4;
              beat1_wdata <= data_wide[63:32];
              beat1_be    <= mask_wide[7:4];
              has_beat1   <= need_beat1;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (has_beat1) begin
              state     <= BEAT1;
              mem_addr  <= beat1_addr;
              mem_wdata <= beat1_wdata;
              mem_be    <= beat1_be;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
              mem_valid <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= '0;
              done      <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// Self-checking bench for store_aligner: byte-level reference model with
// transaction queues, directed test-plan cases and randomized traffic.
module tb_store_aligner;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [6:0]  opcode;
  logic [2:0]  fn3;
  logic [31:0] addr, store_val;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        done, err;

  logic        na_req_valid, na_req_ready;
  logic [6:0]  na_opcode;
  logic [2:0]  na_fn3;
  logic [31:0] na_addr, na_store_val;
  logic        na_mem_valid;
  logic        na_mem_ready;
  logic [31:0] na_mem_addr, na_mem_wdata;
  logic [3:0]  na_mem_be;
  logic        na_done, na_err;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  beat_t beat_q[$];
  bit    cmpl_q[$];

  int checks = 0;
  int failures = 0;
  int expected_done = 0;
  int done_seen = 0;
  int valid_cycles = 0;
  int hs_count = 0;
  int ready_mode = 0;
  logic ready_force = 1'b1;

  always #5 clk = ~clk;

  store_aligner #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .fn3(fn3), .addr(addr), .store_val(store_val),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .done(done), .err(err)
  );

  store_aligner #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst(rst),
    .req_valid(na_req_valid), .req_ready(na_req_ready),
    .opcode(na_opcode), .fn3(na_fn3), .addr(na_addr), .store_val(na_store_val),
    .mem_valid(na_mem_valid), .mem_ready(na_mem_ready),
    .mem_addr(na_mem_addr), .mem_wdata(na_mem_wdata), .mem_be(na_mem_be),
    .done(na_done), .err(na_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: every store byte k lands at global byte position off+k;
  // positions 0-3 belong to the first word, 4-7 to the next word.
  function automatic void modelPush(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] v);
    expected_done++;
    if (op != OP_STORE) begin
      cmpl_q.push_back(1'b0);
    end else if (f3 > 3'd2) begin
      cmpl_q.push_back(1'b1);
    end else begin
      int n;
      int off;
      logic [31:0] b0;
      logic [31:0] b1;
      logic [3:0]  e0;
      logic [3:0]  e1;
      n = 1 << f3;
      off = int'(a[1:0]);
      b0 = '0; b1 = '0; e0 = '0; e1 = '0;
      for (int k = 0; k < n; k++) begin
        int p;
        logic [7:0] byt;
        p = off + k;
        byt = v[8*k +: 8];
        if (p < 4) begin
          b0[8*p +: 8] = byt;
          e0[p] = 1'b1;
        end else begin
          b1[8*(p-4) +: 8] = byt;
          e1[p-4] = 1'b1;
        end
      end
      beat_q.push_back(beat_t'{a & 32'hFFFF_FFFC, b0, e0});
      if (e1 != 4'b0) beat_q.push_back(beat_t'{(a & 32'hFFFF_FFFC) + 32'd4, b1, e1});
      cmpl_q.push_back(1'b0);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] v);
    int waited;
    waited = 0;
    req_valid = 1'b1;
    opcode = op;
    fn3 = f3;
    addr = a;
    store_val = v;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      modelPush(op, f3, a, v);
      #1;
      req_valid = 1'b0;
      opcode = 7'($urandom);
      fn3 = 3'($urandom);
      addr = $urandom;
      store_val = $urandom;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (done_seen != expected_done && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_done_count", 32'(done_seen), 32'(expected_done));
    checkOutput("drain_beats_left", 32'(beat_q.size()), 32'd0);
  endtask

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = 1'($urandom);
        default: mem_ready = ready_force;
      endcase
    end
  end

  // Per-cycle compare of the main DUT against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_valid) begin
          valid_cycles++;
          checkOutput("req_ready_while_busy", 32'(req_ready), 32'd0);
          if (beat_q.size() == 0) begin
            checkOutput("unexpected_beat_mem_valid", 32'(mem_valid), 32'd0);
          end else begin
            checkOutput("beat_addr", mem_addr, beat_q[0].a);
            checkOutput("beat_wdata", mem_wdata, beat_q[0].d);
            checkOutput("beat_be", 32'(mem_be), 32'(beat_q[0].be));
            if (mem_ready) begin
              void'(beat_q.pop_front());
              hs_count++;
            end
          end
        end
        if (done) begin
          checkOutput("done_with_mem_valid", 32'(mem_valid), 32'd0);
          if (cmpl_q.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'd0);
          end else begin
            checkOutput("done_err", 32'(err), 32'(cmpl_q[0]));
            if (!cmpl_q[0]) checkOutput("beats_left_at_done", 32'(beat_q.size()), 32'd0);
            void'(cmpl_q.pop_front());
            done_seen++;
          end
        end else begin
          checkOutput("err_without_done", 32'(err), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0;
    int h0;
    rst = 1'b1;
    req_valid = 1'b0; opcode = '0; fn3 = '0; addr = '0; store_val = '0;
    na_req_valid = 1'b0; na_opcode = '0; na_fn3 = '0; na_addr = '0; na_store_val = '0;
    na_mem_ready = 1'b1;
    #2;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_mem_be", 32'(mem_be), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] case 1: SB lane 3");
    applyStimulus(OP_STORE, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    @(negedge clk);
    checkOutput("sb_valid", 32'(mem_valid), 32'd1);
    checkOutput("sb_addr", mem_addr, 32'h0000_1000);
    checkOutput("sb_be", 32'(mem_be), 32'b1000);
    checkOutput("sb_wdata", mem_wdata, 32'hDD00_0000);
    @(negedge clk);
    checkOutput("sb_done", 32'(done), 32'd1);
    checkOutput("sb_err", 32'(err), 32'd0);
    checkOutput("sb_valid_after", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    waitIdle();

    $display("[TB] case 2: SH upper half");
    applyStimulus(OP_STORE, 3'b001, 32'h0000_2002, 32'hFFFF_1234);
    @(negedge clk);
    checkOutput("sh_addr", mem_addr, 32'h0000_2000);
    checkOutput("sh_be", 32'(mem_be), 32'b1100);
    checkOutput("sh_wdata", mem_wdata, 32'h1234_0000);
    @(posedge clk); #1;
    waitIdle();

    $display("[TB] case 3: split SW");
    applyStimulus(OP_STORE, 3'b010, 32'h0000_3001, 32'h1122_3344);
    @(negedge clk);
    checkOutput("sw0_addr", mem_addr, 32'h0000_3000);
    checkOutput("sw0_be", 32'(mem_be), 32'b1110);
    checkOutput("sw0_wdata", mem_wdata, 32'h2233_4400);
    @(negedge clk);
    checkOutput("sw1_valid", 32'(mem_valid), 32'd1);
    checkOutput("sw1_addr", mem_addr, 32'h0000_3004);
    checkOutput("sw1_be", 32'(mem_be), 32'b0001);
    checkOutput("sw1_wdata", mem_wdata, 32'h0000_0011);
    checkOutput("sw1_no_early_done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("split_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    waitIdle();
    applyStimulus(OP_STORE, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE);
    @(negedge clk);
    checkOutput("wrap0_addr", mem_addr, 32'hFFFF_FFFC);
    checkOutput("wrap0_wdata", mem_wdata, 32'hBABE_0000);
    @(negedge clk);
    checkOutput("wrap1_addr", mem_addr, 32'h0000_0000);
    checkOutput("wrap1_be", 32'(mem_be), 32'b0011);
    checkOutput("wrap1_wdata", mem_wdata, 32'h0000_CAFE);
    @(posedge clk); #1;
    waitIdle();

    $display("[TB] case 4: backpressure");
    ready_mode = 2;
    ready_force = 1'b0;
    v0 = valid_cycles;
    h0 = hs_count;
    applyStimulus(OP_STORE, 3'b010, 32'h0000_4000, 32'h5566_7788);
    repeat (3) @(posedge clk);
    #1;
    ready_force = 1'b1;
    waitIdle();
    checkOutput("stall_valid_cycles", 32'(valid_cycles - v0), 32'd4);
    checkOutput("stall_handshakes", 32'(hs_count - h0), 32'd1);
    ready_mode = 0;

    $display("[TB] case 5: errors and no-op");
    applyStimulus(OP_STORE, 3'b011, 32'h0000_0010, 32'h1234_5678);
    @(negedge clk);
    checkOutput("illegal_done", 32'(done), 32'd1);
    checkOutput("illegal_err", 32'(err), 32'd1);
    checkOutput("illegal_no_beat", 32'(mem_valid), 32'd0);
    @(negedge clk);
    checkOutput("illegal_done_pulse", 32'(done), 32'd0);
    @(posedge clk); #1;
    applyStimulus(OP_LOAD, 3'b010, 32'h0000_0020, 32'h1234_5678);
    @(negedge clk);
    checkOutput("noop_done", 32'(done), 32'd1);
    checkOutput("noop_err", 32'(err), 32'd0);
    checkOutput("noop_no_beat", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    waitIdle();

    na_req_valid = 1'b1; na_opcode = OP_STORE; na_fn3 = 3'b001;
    na_addr = 32'h0000_0003; na_store_val = 32'h0000_BEEF;
    @(negedge clk);
    checkOutput("na_ready", 32'(na_req_ready), 32'd1);
    @(posedge clk); #1;
    na_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("na_mis_done", 32'(na_done), 32'd1);
    checkOutput("na_mis_err", 32'(na_err), 32'd1);
    checkOutput("na_mis_no_beat", 32'(na_mem_valid), 32'd0);
    @(negedge clk);
    checkOutput("na_mis_done_pulse", 32'(na_done), 32'd0);
    @(posedge clk); #1;
    na_req_valid = 1'b1; na_fn3 = 3'b010; na_addr = 32'h0000_0008; na_store_val = 32'h0102_0304;
    @(posedge clk); #1;
    na_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("na_sw_valid", 32'(na_mem_valid), 32'd1);
    checkOutput("na_sw_addr", na_mem_addr, 32'h0000_0008);
    checkOutput("na_sw_be", 32'(na_mem_be), 32'b1111);
    checkOutput("na_sw_wdata", na_mem_wdata, 32'h0102_0304);
    @(negedge clk);
    checkOutput("na_sw_done", 32'(na_done), 32'd1);
    checkOutput("na_sw_err", 32'(na_err), 32'd0);
    @(posedge clk); #1;

    $display("[TB] case 6: reset during second beat");
    applyStimulus(OP_STORE, 3'b010, 32'h0000_3001, 32'h1122_3344);
    @(posedge clk);
    #3;
    checkOutput("pre_reset_beat1_addr", mem_addr, 32'h0000_3004);
    checkOutput("pre_reset_beat1_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset_drops_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset_no_done", 32'(done), 32'd0);
    beat_q.delete();
    cmpl_q.delete();
    expected_done = done_seen;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(req_ready), 32'd1);
    checkOutput("post_reset_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    applyStimulus(OP_STORE, 3'b000, 32'h0000_0005, 32'h1234_5678);
    @(negedge clk);
    checkOutput("post_reset_sb_addr", mem_addr, 32'h0000_0004);
    checkOutput("post_reset_sb_be", 32'(mem_be), 32'b0010);
    checkOutput("post_reset_sb_wdata", mem_wdata, 32'h0000_7800);
    @(posedge clk); #1;
    waitIdle();

    $display("[TB] random traffic");
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      int gap;
      op = ($urandom_range(0, 9) == 0) ? OP_LOAD : OP_STORE;
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      applyStimulus(op, f3, a, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    waitIdle();
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
